// File: rtl/viterbi_pkg.sv
// Shared constants for the Viterbi add-compare-select datapath.
// Modules re-derive PM_MAX/NORM locally from their own PM_W parameter.
package viterbi_pkg;

    localparam int PM_W_DEF = 8;
    localparam int BM_W     = 2;
    localparam int PM_MAX   = (1 << PM_W_DEF) - 1;
    localparam int NORM     = 1 << (PM_W_DEF - 1);

endpackage

// File: rtl/acs_node.sv
// One add-saturate-compare-select-normalize cell; purely combinational.
// Candidate a belongs to predecessor 2j and wins ties.
module acs_node
    import viterbi_pkg::*;
#(
    parameter int PM_W = PM_W_DEF
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [BM_W-1:0] bm_a,
    input  logic [BM_W-1:0] bm_b,
    input  logic            norm,
    output logic [PM_W-1:0] pm_sel,
    output logic            dec
);

    localparam logic [PM_W-1:0] PM_MAX_L = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] NORM_L   = {1'b1, {(PM_W-1){1'b0}}};

    logic [PM_W:0]   sum_a_s;
    logic [PM_W:0]   sum_b_s;
    logic [PM_W-1:0] cand_a_s;
    logic [PM_W-1:0] cand_b_s;
    logic [PM_W-1:0] win_s;

    // Add in PM_W+1 bits, saturate, select the smaller candidate, then normalize.
    always_comb begin
        sum_a_s  = {1'b0, pm_a} + {{(PM_W+1-BM_W){1'b0}}, bm_a};
        sum_b_s  = {1'b0, pm_b} + {{(PM_W+1-BM_W){1'b0}}, bm_b};
        cand_a_s = PM_MAX_L;
        cand_b_s = PM_MAX_L;
        win_s    = PM_MAX_L;
        pm_sel   = PM_MAX_L;
        dec      = 1'b0;

        if (sum_a_s[PM_W]) begin
            cand_a_s = PM_MAX_L;
        end else begin
            cand_a_s = sum_a_s[PM_W-1:0];
        end

        if (sum_b_s[PM_W]) begin
            cand_b_s = PM_MAX_L;
        end else begin
            cand_b_s = sum_b_s[PM_W-1:0];
        end

        dec = (cand_b_s < cand_a_s);
        if (dec) begin
            win_s = cand_b_s;
        end else begin
            win_s = cand_a_s;
        end

        // Clamp protects against an under-normalized metric wrapping to a huge value.
        if (norm) begin
            if (win_s >= NORM_L) begin
                pm_sel = win_s - NORM_L;
            end else begin
                pm_sel = {PM_W{1'b0}};
            end
        end else begin
            pm_sel = win_s;
        end
    end

endmodule

// File: rtl/acs_butterfly.sv
// Radix-2 ACS butterfly: two acs_node cells with antipodal branch pairing,
// registered metrics and decisions, one-cycle latency.
module acs_butterfly
    import viterbi_pkg::*;
#(
    parameter int PM_W      = PM_W_DEF,
    parameter bit IS_STATE0 = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            init,
    input  logic            in_valid,
    input  logic [BM_W-1:0] bm_0,
    input  logic [BM_W-1:0] bm_1,
    input  logic [PM_W-1:0] pm_in_0,
    input  logic [PM_W-1:0] pm_in_1,
    input  logic            norm,
    output logic [PM_W-1:0] pm_out_0,
    output logic [PM_W-1:0] pm_out_1,
    output logic            dec_0,
    output logic            dec_1,
    output logic            out_valid,
    output logic            pm_msb
);

    localparam logic [PM_W-1:0] PM_MAX_L = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] PM0_INIT = IS_STATE0 ? {PM_W{1'b0}} : PM_MAX_L;

    logic            norm_s;
    logic [PM_W-1:0] sel_0_s;
    logic [PM_W-1:0] sel_1_s;
    logic            dsel_0_s;
    logic            dsel_1_s;
    logic [PM_W-1:0] pm_0_r;
    logic [PM_W-1:0] pm_1_r;
    logic            dec_0_r;
    logic            dec_1_r;
    logic            valid_r;

    assign norm_s = norm & in_valid;

    acs_node #(.PM_W(PM_W)) u_node_0 (
        .pm_a   (pm_in_0),
        .pm_b   (pm_in_1),
        .bm_a   (bm_0),
        .bm_b   (bm_1),
        .norm   (norm_s),
        .pm_sel (sel_0_s),
        .dec    (dsel_0_s)
    );

    acs_node #(.PM_W(PM_W)) u_node_1 (
        .pm_a   (pm_in_0),
        .pm_b   (pm_in_1),
        .bm_a   (bm_1),
        .bm_b   (bm_0),
        .norm   (norm_s),
        .pm_sel (sel_1_s),
        .dec    (dsel_1_s)
    );

    // State registers: init beats in_valid; idle cycles hold metrics and decisions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_0_r  <= PM0_INIT;
            pm_1_r  <= PM_MAX_L;
            dec_0_r <= 1'b0;
            dec_1_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (init) begin
            pm_0_r  <= PM0_INIT;
            pm_1_r  <= PM_MAX_L;
            dec_0_r <= 1'b0;
            dec_1_r <= 1'b0;
            valid_r <= 1'b0;
        end else if (in_valid) begin
            pm_0_r  <= sel_0_s;
            pm_1_r  <= sel_1_s;
            dec_0_r <= dsel_0_s;
            dec_1_r <= dsel_1_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    assign pm_out_0  = pm_0_r;
    assign pm_out_1  = pm_1_r;
    assign dec_0     = dec_0_r;
    assign dec_1     = dec_1_r;
    assign out_valid = valid_r;
    assign pm_msb    = pm_0_r[PM_W-1] & pm_1_r[PM_W-1];

endmodule

// File: tb/tb_acs_butterfly.sv
// Directed table-driven bench for acs_butterfly (PM_W=8), with a second
// instance built as the state-0 butterfly sharing the same stimulus.
module tb_acs_butterfly;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] bm_0 = 2'd0;
    logic [1:0] bm_1 = 2'd0;
    logic [7:0] pm_in_0 = 8'd0;
    logic [7:0] pm_in_1 = 8'd0;
    logic       norm = 1'b0;

    logic [7:0] pm_out_0, pm_out_1, s0_pm_out_0, s0_pm_out_1;
    logic       dec_0, dec_1, out_valid, pm_msb;
    logic       s0_dec_0, s0_dec_1, s0_out_valid, s0_pm_msb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    acs_butterfly #(.PM_W(8), .IS_STATE0(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .init(init), .in_valid(in_valid),
        .bm_0(bm_0), .bm_1(bm_1), .pm_in_0(pm_in_0), .pm_in_1(pm_in_1),
        .norm(norm), .pm_out_0(pm_out_0), .pm_out_1(pm_out_1),
        .dec_0(dec_0), .dec_1(dec_1), .out_valid(out_valid), .pm_msb(pm_msb)
    );

    acs_butterfly #(.PM_W(8), .IS_STATE0(1'b1)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .init(init), .in_valid(in_valid),
        .bm_0(bm_0), .bm_1(bm_1), .pm_in_0(pm_in_0), .pm_in_1(pm_in_1),
        .norm(norm), .pm_out_0(s0_pm_out_0), .pm_out_1(s0_pm_out_1),
        .dec_0(s0_dec_0), .dec_1(s0_dec_1), .out_valid(s0_out_valid), .pm_msb(s0_pm_msb)
    );

    typedef struct {
        int init, iv, nrm, b0, b1, p0, p1;
        int e_pm0, e_pm1, e_d0, e_d1, e_ov, e_msb, e_s0pm0;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input int e0, input int e1, input int ed0,
                              input int ed1, input int eov, input int emsb, input int es0);
        check({tag, " pm_out_0"}, int'(pm_out_0), e0);
        check({tag, " pm_out_1"}, int'(pm_out_1), e1);
        check({tag, " dec_0"}, int'(dec_0), ed0);
        check({tag, " dec_1"}, int'(dec_1), ed1);
        check({tag, " out_valid"}, int'(out_valid), eov);
        check({tag, " pm_msb"}, int'(pm_msb), emsb);
        check({tag, " s0 pm_out_0"}, int'(s0_pm_out_0), es0);
    endtask

    initial begin
        //           init iv nrm b0 b1  p0   p1   pm0 pm1 d0 d1 ov msb s0pm0
        vecs[0]  = '{0, 1, 0, 2, 0,  10,  20,  12, 10, 0, 0, 1, 0,  12};
        vecs[1]  = '{0, 1, 0, 1, 1,  20,  10,  11, 11, 1, 1, 1, 0,  11};
        vecs[2]  = '{0, 1, 0, 1, 1,   5,   5,   6,  6, 0, 0, 1, 0,   6};
        vecs[3]  = '{0, 1, 0, 2, 2, 254, 255, 255,255, 0, 0, 1, 1, 255};
        vecs[4]  = '{0, 1, 1, 0, 1, 200, 210,  72, 73, 0, 0, 1, 0,  72};
        vecs[5]  = '{0, 1, 1, 0, 0,  50,  60,   0,  0, 0, 0, 1, 0,   0};
        vecs[6]  = '{0, 0, 1, 1, 1,   1,   1,   0,  0, 0, 0, 0, 0,   0};
        vecs[7]  = '{0, 1, 0, 0, 2, 100,   3,   5,  3, 1, 1, 1, 0,   5};
        vecs[8]  = '{0, 0, 0, 2, 2,  40,  90,   5,  3, 1, 1, 0, 0,   5};
        vecs[9]  = '{1, 1, 0, 0, 0,   1,   2, 255,255, 0, 0, 0, 1,   0};
        vecs[10] = '{0, 1, 0, 1, 0,   7,   9,   8,  7, 0, 0, 1, 0,   8};

        // Reset state
        #12;
        check_outs("reset", 255, 255, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            init     = vecs[i].init[0];
            in_valid = vecs[i].iv[0];
            norm     = vecs[i].nrm[0];
            bm_0     = 2'(vecs[i].b0);
            bm_1     = 2'(vecs[i].b1);
            pm_in_0  = 8'(vecs[i].p0);
            pm_in_1  = 8'(vecs[i].p1);
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_pm0, vecs[i].e_pm1, vecs[i].e_d0,
                       vecs[i].e_d1, vecs[i].e_ov, vecs[i].e_msb, vecs[i].e_s0pm0);
        end

        // Mid-stream reset: valid data keeps flowing while rst_n drops
        @(negedge clk);
        init = 1'b0; in_valid = 1'b1; norm = 1'b0;
        bm_0 = 2'd1; bm_1 = 2'd1; pm_in_0 = 8'd20; pm_in_1 = 8'd10;
        @(posedge clk);
        #1;
        check_outs("pre_rst", 11, 11, 1, 1, 1, 0, 11);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_rst", 255, 255, 0, 0, 0, 1, 0);
        @(posedge clk);
        #1;
        check_outs("rst_hold", 255, 255, 0, 0, 0, 1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("post_rst_idle", 255, 255, 0, 0, 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b1; bm_0 = 2'd2; bm_1 = 2'd0; pm_in_0 = 8'd10; pm_in_1 = 8'd20;
        @(posedge clk);
        #1;
        check_outs("post_rst_valid", 12, 10, 0, 0, 1, 0, 12);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check_outs("gap_hold", 12, 10, 0, 0, 0, 0, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
